// File: rtl/fill_pkg.sv
// Shared fill definitions: widths, header bit offsets and one-hot state encoding.
// Also consumed by the fill reader, which unpacks the header with the same offsets.
package fill_pkg;

  localparam int unsigned ADDR_W     = 23;
  localparam int unsigned CNT_W      = 24;
  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned TS_W       = 28;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned HDR_W      = 152;

  // Header layout: {cnt, timestamp, cnt, start_addr, 29'b0, fill number}
  localparam int unsigned CNT_LSB     = 128;
  localparam int unsigned TS_LSB      = 100;
  localparam int unsigned CNT2_LSB    = 76;
  localparam int unsigned ADDR_LSB    = 53;
  localparam int unsigned FILLNUM_LSB = 0;

  // One-hot state bit positions
  localparam int unsigned ST_IDLE     = 0;
  localparam int unsigned ST_LATCH    = 1;
  localparam int unsigned ST_WRITE    = 2;
  localparam int unsigned ST_DRAIN    = 3;
  localparam int unsigned ST_PUSH_HDR = 4;
  localparam int unsigned ST_DONE     = 5;
  localparam int unsigned NUM_STATES  = 6;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE     = NUM_STATES'(1 << ST_IDLE),
    S_LATCH    = NUM_STATES'(1 << ST_LATCH),
    S_WRITE    = NUM_STATES'(1 << ST_WRITE),
    S_DRAIN    = NUM_STATES'(1 << ST_DRAIN),
    S_PUSH_HDR = NUM_STATES'(1 << ST_PUSH_HDR),
    S_DONE     = NUM_STATES'(1 << ST_DONE)
  } state_e;

  // Fields latched per fill that make up the header
  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  fill_num;
  } hdr_fields_t;

endpackage

// File: rtl/fill_hdr_pack.sv
// Combinational fill header assembly from the latched per-fill fields.
module fill_hdr_pack
  import fill_pkg::*;
(
  input  hdr_fields_t        fields_i,
  output logic [HDR_W-1:0]   hdr_o
);

  // Place each field at its fixed offset; unused span [52:24] stays zero
  always_comb begin
    hdr_o = '0;
    hdr_o[CNT_LSB     +: CNT_W]  = fields_i.cnt;
    hdr_o[TS_LSB      +: TS_W]   = fields_i.ts;
    hdr_o[CNT2_LSB    +: CNT_W]  = fields_i.cnt;
    hdr_o[ADDR_LSB    +: ADDR_W] = fields_i.start_addr;
    hdr_o[FILLNUM_LSB +: CNT_W]  = fields_i.fill_num;
  end

endmodule

// File: rtl/fill_wr_sm.sv
// Fill writer: on a trigger, streams a fixed number of ADC bursts into DDR3 at
// consecutive (wrapping) addresses, then pushes one fill header into the header FIFO.
// Optional feature macro: FILL_TIMESTAMP_EN (free-running cycle counter sampled
// into header[127:100] on each accepted trigger).
module fill_wr_sm
  import fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  trig,
  input  logic [CNT_W-1:0]      trig_num,
  input  logic [CNT_W-1:0]      burst_cnt_cfg,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  output logic                  adc_ready,
  output logic [ADDR_W-1:0]     ddr3_wr_addr,
  output logic [DATA_W-1:0]     ddr3_wr_data,
  output logic                  ddr3_wr_valid,
  input  logic                  ddr3_wr_ready,
  input  logic                  fill_header_fifo_full,
  output logic                  fill_header_fifo_wr_en,
  output logic [HDR_W-1:0]      fill_header_fifo_in,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] trig_dropped_cnt
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        acc_q;
  logic [CNT_W-1:0]        fillnum_q;
  logic [ADDR_W-1:0]       start_q;
  logic [ADDR_W-1:0]       next_addr_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_W-1:0]       wr_data_q;
  logic                    wr_valid_q;
  logic [DROP_CNT_W-1:0]   drop_q;
  logic [TS_W-1:0]         ts_hdr;
  logic [HDR_W-1:0]        hdr;
  logic [ADDR_W-1:0]       beat_addr;
  hdr_fields_t             hdr_fields;
  logic                    trig_acc;
  logic                    beat_acc;
  logic                    ddr_acc;
  logic                    push;

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    trig_acc  = trig && enable && (state_q == S_IDLE);
    adc_ready = enable && (state_q == S_WRITE) &&
                (!wr_valid_q || ddr3_wr_ready) && (acc_q < cnt_q);
    beat_acc  = adc_valid && adc_ready;
    ddr_acc   = wr_valid_q && ddr3_wr_ready;
    push      = enable && (state_q == S_PUSH_HDR) && !fill_header_fifo_full;
    beat_addr = start_q + ADDR_W'(acc_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; enable low forces IDLE on the next cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (trig_acc) state_d = S_LATCH;
      S_LATCH:    state_d = (cnt_q == '0) ? S_PUSH_HDR : S_WRITE;
      S_WRITE:    if (acc_q == cnt_q) state_d = S_DRAIN;
      S_DRAIN:    if (!wr_valid_q || ddr3_wr_ready) state_d = S_PUSH_HDR;
      S_PUSH_HDR: if (!fill_header_fifo_full) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // Per-fill latches and the DDR3 write holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      fillnum_q   <= '0;
      start_q     <= '0;
      next_addr_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
    end else if (!enable) begin
      // Abort drops any pending write; next_addr_q survives
      acc_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
    end else begin
      if (trig_acc) begin
        fillnum_q <= trig_num;
        cnt_q     <= burst_cnt_cfg;
        start_q   <= next_addr_q;
        acc_q     <= '0;
      end
      if (beat_acc) begin
        wr_data_q   <= adc_data;
        wr_addr_q   <= beat_addr;
        wr_valid_q  <= 1'b1;
        acc_q       <= acc_q + CNT_W'(1);
        next_addr_q <= beat_addr + ADDR_W'(1);
      end else if (ddr_acc) begin
        wr_valid_q  <= 1'b0;
      end
      if (state_q == S_DONE) begin
        next_addr_q <= start_q + ADDR_W'(cnt_q);
      end
    end
  end

  // Saturating count of triggers that could not start a fill
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (trig && !trig_acc && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

`ifdef FILL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_lat_q;

  // Free-running cycle counter, sampled when a fill starts
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      if (trig_acc) ts_lat_q <= ts_cnt_q;
    end
  end

  assign ts_hdr = ts_lat_q;
`else
  assign ts_hdr = '0;
`endif

  // Header fields and assembly
  always_comb begin
    hdr_fields.cnt        = cnt_q;
    hdr_fields.ts         = ts_hdr;
    hdr_fields.start_addr = start_q;
    hdr_fields.fill_num   = fillnum_q;
  end

  fill_hdr_pack u_hdr_pack (
    .fields_i (hdr_fields),
    .hdr_o    (hdr)
  );

  // Output drive; header bus is zero except during the push cycle
  always_comb begin
    ddr3_wr_addr           = wr_addr_q;
    ddr3_wr_data           = wr_data_q;
    ddr3_wr_valid          = wr_valid_q;
    fill_header_fifo_wr_en = push;
    fill_header_fifo_in    = push ? hdr : '0;
    busy                   = (state_q != S_IDLE);
    trig_dropped_cnt       = drop_q;
  end

endmodule

// File: tb/tb_fill_wr_sm.sv
// Directed bench for fill_wr_sm: address sequencing/wrap, backpressure, header content,
// header FIFO full stall, header-only fills and dropped-trigger counting.
module tb_fill_wr_sm;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         trig;
  logic [23:0]  trig_num;
  logic [23:0]  burst_cnt_cfg;
  logic [127:0] adc_data;
  logic         adc_valid;
  logic         adc_ready;
  logic [22:0]  ddr3_wr_addr;
  logic [127:0] ddr3_wr_data;
  logic         ddr3_wr_valid;
  logic         ddr3_wr_ready;
  logic         fill_header_fifo_full;
  logic         fill_header_fifo_wr_en;
  logic [151:0] fill_header_fifo_in;
  logic         busy;
  logic [15:0]  trig_dropped_cnt;

  fill_wr_sm dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .trig                   (trig),
    .trig_num               (trig_num),
    .burst_cnt_cfg          (burst_cnt_cfg),
    .adc_data               (adc_data),
    .adc_valid              (adc_valid),
    .adc_ready              (adc_ready),
    .ddr3_wr_addr           (ddr3_wr_addr),
    .ddr3_wr_data           (ddr3_wr_data),
    .ddr3_wr_valid          (ddr3_wr_valid),
    .ddr3_wr_ready          (ddr3_wr_ready),
    .fill_header_fifo_full  (fill_header_fifo_full),
    .fill_header_fifo_wr_en (fill_header_fifo_wr_en),
    .fill_header_fifo_in    (fill_header_fifo_in),
    .busy                   (busy),
    .trig_dropped_cnt       (trig_dropped_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [22:0]  addr;
    logic [127:0] data;
    int           c;
  } beat_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           trig_cyc;
  int           hdr_cyc;
  int           full_push_err;
  int           proto_err;
  beat_t        beat_q[$];
  logic [151:0] hdr_q[$];

  always @(posedge clk) cyc++;

  // Record accepted DDR3 beats and header pushes; flag held-request instability
  logic         prev_stall = 1'b0;
  logic [22:0]  prev_addr;
  logic [127:0] prev_data;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!ddr3_wr_valid || ddr3_wr_addr !== prev_addr || ddr3_wr_data !== prev_data))
        proto_err++;
      prev_stall = ddr3_wr_valid && !ddr3_wr_ready;
      prev_addr  = ddr3_wr_addr;
      prev_data  = ddr3_wr_data;
      if (ddr3_wr_valid && ddr3_wr_ready) beat_q.push_back('{ddr3_wr_addr, ddr3_wr_data, cyc});
      if (fill_header_fifo_wr_en) begin
        hdr_q.push_back(fill_header_fifo_in);
        hdr_cyc = cyc;
        if (fill_header_fifo_full) full_push_err++;
      end
    end
  end

  function automatic logic [127:0] bdata(input logic [23:0] tn, input int i);
    return {8'h5A, tn, 32'(i), 32'h0BAD_F00D ^ 32'(i), ~32'(i)};
  endfunction

  function automatic logic [151:0] exp_hdr(input logic [23:0] cnt, input logic [22:0] start,
                                           input logic [23:0] tn);
    return {cnt, 28'h0, cnt, start, 29'h0, tn};
  endfunction

  function automatic logic [151:0] mask_ts(input logic [151:0] h);
    logic [151:0] r;
    r = h;
`ifdef FILL_TIMESTAMP_EN
    r[127:100] = '0;
`endif
    return r;
  endfunction

  // Drive one fill: trigger, ADC source, DDR3 ready pattern, header FIFO full hold
  task automatic run_fill(input logic [23:0] cnt, input logic [23:0] tnum, input bit rand_valid,
                          input bit toggle_ready, input int full_hold, input bit extra_trig,
                          input bit rel_force, output bit timed_out);
    int src;
    int held;
    bit done;
    src = 0; held = 0; done = 0;
    beat_q.delete(); hdr_q.delete();
    full_push_err = 0; proto_err = 0; hdr_cyc = 0;
    @(posedge clk); #1;
    trig = 1'b1; trig_num = tnum; burst_cnt_cfg = cnt; trig_cyc = cyc;
    fill_header_fifo_full = (full_hold > 0);
    adc_data = bdata(tnum, 0);
    adc_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    ddr3_wr_ready = 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (adc_valid && adc_ready) src++;
      if (fill_header_fifo_full && beat_q.size() == int'(cnt)) held++;
      @(posedge clk); #1;
      if (rel_force && t == 0) release dut.next_addr_q;
      trig = extra_trig && (t == 0);
      if (held >= full_hold) fill_header_fifo_full = 1'b0;
      adc_data = bdata(tnum, src);
      adc_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      ddr3_wr_ready = toggle_ready ? ~ddr3_wr_ready : 1'b1;
      if (!busy) done = 1'b1;
    end
    trig = 1'b0; adc_valid = 1'b0; fill_header_fifo_full = 1'b0; ddr3_wr_ready = 1'b1;
    timed_out = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; trig = 1'b0; trig_num = '0; burst_cnt_cfg = '0;
    adc_data = '0; adc_valid = 1'b0; ddr3_wr_ready = 1'b1; fill_header_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (adc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_adc_ready: got %0b expected 0", adc_ready); end
    n_checks++; if (ddr3_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %0b expected 0", ddr3_wr_valid); end
    n_checks++; if (ddr3_wr_addr !== 23'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h expected 0", ddr3_wr_addr); end
    n_checks++; if (ddr3_wr_data !== 128'h0) begin n_fail++; $display("FAIL reset_wr_data: got %0h expected 0", ddr3_wr_data); end
    n_checks++; if (fill_header_fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", fill_header_fifo_wr_en); end
    n_checks++; if (fill_header_fifo_in !== 152'h0) begin n_fail++; $display("FAIL reset_hdr_in: got %0h expected 0", fill_header_fifo_in); end
    n_checks++; if (trig_dropped_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", trig_dropped_cnt); end
  endtask

  task automatic test_basic_fill();
    bit to;
    run_fill(24'd4, 24'h000123, 1'b0, 1'b0, 0, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: fill did not return to idle"); end
    n_checks++; if (beat_q.size() != 4) begin n_fail++; $display("FAIL basic_beats: got %0d expected 4", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 4; k++) begin
      n_checks++;
      if (beat_q[k].addr !== 23'(k) || beat_q[k].data !== bdata(24'h000123, k)) begin
        n_fail++; $display("FAIL basic_beat%0d: got addr %0h data %0h expected addr %0h data %0h",
                           k, beat_q[k].addr, beat_q[k].data, 23'(k), bdata(24'h000123, k));
      end
    end
    if (beat_q.size() == 4) begin
      n_checks++; if (beat_q[0].c - trig_cyc != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", beat_q[0].c - trig_cyc); end
      n_checks++; if (beat_q[3].c - beat_q[0].c != 3) begin n_fail++; $display("FAIL basic_throughput: got %0d expected 3", beat_q[3].c - beat_q[0].c); end
    end
    n_checks++; if (hdr_q.size() != 1) begin n_fail++; $display("FAIL basic_push_count: got %0d expected 1", hdr_q.size()); end
    if (hdr_q.size() > 0) begin
      n_checks++;
      if (mask_ts(hdr_q[0]) !== exp_hdr(24'd4, 23'h0, 24'h000123)) begin
        n_fail++; $display("FAIL basic_header: got %0h expected %0h", hdr_q[0], exp_hdr(24'd4, 23'h0, 24'h000123));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    run_fill(24'd4, 24'h000456, 1'b0, 1'b0, 0, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: fill did not return to idle"); end
    n_checks++; if (beat_q.size() != 4) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 4", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 4; k++) begin
      n_checks++;
      if (beat_q[k].addr !== 23'(4 + k)) begin
        n_fail++; $display("FAIL b2b_addr%0d: got %0h expected %0h", k, beat_q[k].addr, 23'(4 + k));
      end
    end
    n_checks++;
    if (hdr_q.size() != 1 || mask_ts(hdr_q[0]) !== exp_hdr(24'd4, 23'h4, 24'h000456)) begin
      n_fail++; $display("FAIL b2b_header: got %0d pushes first %0h expected 1 push %0h",
                         hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0] : 152'h0, exp_hdr(24'd4, 23'h4, 24'h000456));
    end
  endtask

  task automatic test_addr_wrap();
    bit to;
    logic [22:0] exp_a [4];
    exp_a[0] = 23'h7FFFFE; exp_a[1] = 23'h7FFFFF; exp_a[2] = 23'h000000; exp_a[3] = 23'h000001;
    force dut.next_addr_q = 23'h7FFFFE;
    run_fill(24'd4, 24'h000789, 1'b0, 1'b0, 0, 1'b0, 1'b1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL wrap_timeout: fill did not return to idle"); end
    n_checks++; if (beat_q.size() != 4) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 4", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 4; k++) begin
      n_checks++;
      if (beat_q[k].addr !== exp_a[k]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %0h expected %0h", k, beat_q[k].addr, exp_a[k]);
      end
    end
    n_checks++;
    if (hdr_q.size() != 1 || mask_ts(hdr_q[0]) !== exp_hdr(24'd4, 23'h7FFFFE, 24'h000789)) begin
      n_fail++; $display("FAIL wrap_header: got %0d pushes first %0h expected 1 push %0h",
                         hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0] : 152'h0, exp_hdr(24'd4, 23'h7FFFFE, 24'h000789));
    end
  endtask

  task automatic test_header_only();
    bit to;
    run_fill(24'd0, 24'h000ABC, 1'b0, 1'b0, 0, 1'b1, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL hdronly_timeout: fill did not return to idle"); end
    n_checks++; if (beat_q.size() != 0) begin n_fail++; $display("FAIL hdronly_beats: got %0d expected 0", beat_q.size()); end
    n_checks++;
    if (hdr_q.size() != 1 || mask_ts(hdr_q[0]) !== exp_hdr(24'd0, 23'h2, 24'h000ABC)) begin
      n_fail++; $display("FAIL hdronly_header: got %0d pushes first %0h expected 1 push %0h",
                         hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0] : 152'h0, exp_hdr(24'd0, 23'h2, 24'h000ABC));
    end
    n_checks++; if (trig_dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL hdronly_drop_cnt: got %0d expected 1", trig_dropped_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    run_fill(24'd10, 24'h0000BE, 1'b1, 1'b1, 0, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: fill did not return to idle"); end
    n_checks++; if (beat_q.size() != 10) begin n_fail++; $display("FAIL bp_beats: got %0d expected 10", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 10; k++) begin
      n_checks++;
      if (beat_q[k].addr !== 23'(2 + k) || beat_q[k].data !== bdata(24'h0000BE, k)) begin
        n_fail++; $display("FAIL bp_beat%0d: got addr %0h data %0h expected addr %0h data %0h",
                           k, beat_q[k].addr, beat_q[k].data, 23'(2 + k), bdata(24'h0000BE, k));
      end
    end
    n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d violations expected 0", proto_err); end
    n_checks++;
    if (hdr_q.size() != 1 || mask_ts(hdr_q[0]) !== exp_hdr(24'd10, 23'h2, 24'h0000BE)) begin
      n_fail++; $display("FAIL bp_header: got %0d pushes first %0h expected 1 push %0h",
                         hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0] : 152'h0, exp_hdr(24'd10, 23'h2, 24'h0000BE));
    end
  endtask

  task automatic test_fifo_full();
    bit to;
    run_fill(24'd2, 24'h0000FF, 1'b0, 1'b0, 20, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL full_timeout: fill did not return to idle"); end
    n_checks++; if (beat_q.size() != 2) begin n_fail++; $display("FAIL full_beats: got %0d expected 2", beat_q.size()); end
    n_checks++; if (full_push_err != 0) begin n_fail++; $display("FAIL full_push_while_full: got %0d expected 0", full_push_err); end
    n_checks++;
    if (hdr_q.size() != 1 || mask_ts(hdr_q[0]) !== exp_hdr(24'd2, 23'hC, 24'h0000FF)) begin
      n_fail++; $display("FAIL full_header: got %0d pushes first %0h expected 1 push %0h",
                         hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0] : 152'h0, exp_hdr(24'd2, 23'hC, 24'h0000FF));
    end
    if (beat_q.size() == 2) begin
      n_checks++;
      if (hdr_cyc - beat_q[1].c < 20) begin
        n_fail++; $display("FAIL full_push_delay: got %0d cycles expected at least 20", hdr_cyc - beat_q[1].c);
      end
    end
    n_checks++; if (trig_dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL full_drop_cnt: got %0d expected 1", trig_dropped_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_back_to_back();
    test_addr_wrap();
    test_header_only();
    test_backpressure();
    test_fifo_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
